// File: rtl/rtc_kw8.sv
// rtc_kw8 -- programmable real-time clock, IOT device 13.
// clk is divided down to a selectable tick rate. Each tick increments a
// 12-bit counter. When the counter overflows, a flag is set and the counter
// restarts from 0 (free-run) or from a buffer register (reload mode).
//
// Ports
//   clk          system clock (clk100 at top level)
//   reset        synchronous, active-high reset
//   clear        front-panel CLEAR; same effect as reset
//   state        CPU major state; an IOT is decoded only in F1
//   instruction  current instruction register (bit 11 = PDP-8 bit 0)
//   ac           accumulator (bit 11 = PDP-8 bit 0)
//   UF           user-mode flag; blocks IOT decode when 1
//   rtc_bus      read data to imux, 0 when not reading
//   skip         IOT skip request to imux
//   interrupt    flag & ie
//
// Bit numbering: the PDP-8 field [a:b] is vector bit [11-a:11-b].
// A CLK_HZ value below 10000 is illegal. The terminal counts truncate.
module rtc_kw8 #(
  parameter int          CLK_HZ = 100000000,
  parameter logic [5:0]  DEV    = 6'o13,
  // F1 encoding as defined in the shared CPU parameters
  parameter logic [4:0]  F1     = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [4:0]  state,
  input  logic [11:0] instruction,
  input  logic [11:0] ac,
  input  logic        UF,
  output logic [11:0] rtc_bus,
  output logic        skip,
  output logic        interrupt
);

  localparam int PW = $clog2(CLK_HZ / 100);
  localparam logic [PW-1:0] TC_100  = PW'(CLK_HZ / 100 - 1);
  localparam logic [PW-1:0] TC_1K   = PW'(CLK_HZ / 1000 - 1);
  localparam logic [PW-1:0] TC_10K  = PW'(CLK_HZ / 10000 - 1);

  localparam logic [2:0] CLNOP = 3'd0, CLSK = 3'd1, CLLR = 3'd2, CLAB = 3'd3,
                         CLRC  = 3'd4, CLRS = 3'd5, CLCL = 3'd6, CLSI = 3'd7;

  logic [11:0]   cnt, reload_buf;
  logic [1:0]    rate;
  logic          ie, mode, flag;
  logic [PW-1:0] pre, tc;
  logic          hit, tick, ovf;
  logic [2:0]    fn;

  assign hit  = (state == F1) && (instruction[11:9] == 3'o6) &&
                (instruction[8:3] == DEV) && !UF;
  assign fn   = instruction[2:0];

  always_comb begin
    tc = '0;
    case (rate)
      2'b01:   tc = TC_100;
      2'b10:   tc = TC_1K;
      2'b11:   tc = TC_10K;
      default: tc = '0;
    endcase
  end

  assign tick = (rate != 2'b00) && (pre == tc);
  assign ovf  = tick && (cnt == 12'o7777);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt        <= '0;
      reload_buf <= '0;
      rate       <= '0;
      ie         <= 1'b0;
      mode       <= 1'b0;
      flag       <= 1'b0;
      pre        <= '0;
    end else begin
      if (rate == 2'b00 || tick) pre <= '0;
      else                       pre <= pre + PW'(1);

      if (tick) cnt <= ovf ? (mode ? reload_buf : 12'o0000) : cnt + 12'd1;

      // A flag clear and an overflow on the same edge leave the flag set.
      if (hit && (fn == CLSK || fn == CLCL)) flag <= 1'b0;
      if (ovf)                               flag <= 1'b1;

      // These IOTs come last so they override the prescaler and counter
      // updates above. A tick that coincides with CLAB is lost. A tick that
      // coincides with CLLR has already reached cnt.
      if (hit) begin
        case (fn)
          CLLR: begin
            rate <= ac[11:10];
            ie   <= ac[9];
            mode <= ac[8];
            pre  <= '0;
          end
          CLAB: begin
            reload_buf <= ac;
            cnt        <= ac;
            pre        <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rtc_bus = '0;
    skip    = 1'b0;
    if (hit) begin
      case (fn)
        CLSK:    skip    = flag;
        CLSI:    skip    = flag & ie;
        CLRC:    rtc_bus = cnt;
        CLRS:    rtc_bus = {rate, ie, mode, 7'b0, flag};
        default: ;
      endcase
    end
  end

  assign interrupt = flag & ie;

endmodule
